// File: rtl/sound_pkg.sv
// Shared types, constants and the fixed lead-voice song table.
package sound_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StTail
  } seq_state_t;

  localparam logic [4:0] ENV_MAX   = 5'd31;
  localparam logic [4:0] NOTE_REST = 5'd0;
  localparam logic [4:0] NOTE_A    = 5'd28;
  localparam logic [4:0] NOTE_B    = 5'd25;
  localparam logic [4:0] NOTE_C    = 5'd24;

  // Period code for each of the 16 song steps.
  function automatic logic [4:0] song_freq(input logic [3:0] idx);
    logic [4:0] f;
    unique case (idx)
      4'd0, 4'd4, 4'd8, 4'd12, 4'd13: f = NOTE_B;
      4'd1, 4'd5, 4'd9, 4'd14:        f = NOTE_C;
      4'd2, 4'd6, 4'd7, 4'd11:        f = NOTE_A;
      default:                        f = NOTE_REST;
    endcase
    return f;
  endfunction

  // A rest starts silent; any real note starts at full envelope.
  function automatic logic [4:0] note_env(input logic [4:0] freq);
    return (freq == NOTE_REST) ? 5'd0 : ENV_MAX;
  endfunction

endpackage

// File: rtl/sound_envelope.sv
// Saturating decay register for the lead-voice gate envelope.
module sound_envelope #(
  parameter int unsigned ENV_DECAY = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic [4:0] load_val,
  input  logic       decay,
  output logic [4:0] env
);

  localparam logic [5:0] Decay6 = 6'(ENV_DECAY);

  logic [4:0] env_q, env_d;
  logic [5:0] env_wide;

  assign env_wide = {1'b0, env_q};
  assign env      = env_q;

  // Next envelope: clear beats load beats decay; decay floors at zero.
  always_comb begin
    env_d = env_q;
    if (clear) begin
      env_d = 5'd0;
    end else if (load) begin
      env_d = load_val;
    end else if (decay) begin
      env_d = (env_wide > Decay6) ? 5'(env_wide - Decay6) : 5'd0;
    end
  end

  // Envelope register.
  always_ff @(posedge clk) begin
    if (rst) env_q <= 5'd0;
    else     env_q <= env_d;
  end

endmodule

// File: rtl/sound_sequencer.sv
// Frame-rate song sequencer for the square-wave lead voice.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int unsigned FRAMES_PER_STEP = 4,
  parameter int unsigned ENV_DECAY       = 8,
  parameter int unsigned NUM_STEPS       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  output logic [4:0] note_freq,
  output logic [4:0] envelope,
  output logic       note_valid,
  output logic [3:0] step_idx,
  output logic       playing,
  output logic       done
);

  localparam logic [3:0] LastStep  = 4'(NUM_STEPS - 1);
  localparam logic [3:0] StepTicks = 4'(FRAMES_PER_STEP);

  seq_state_t state_q, state_d;
  logic [3:0] frame_cnt_q, frame_cnt_d;
  logic [3:0] step_q, step_d;
  logic [4:0] note_q, note_d;
  logic       valid_q, valid_d;
  logic       done_q, done_d;
  logic       playing_q, playing_d;

  logic       go_idle, do_load;
  logic [3:0] load_idx;
  logic       env_clear, env_load, env_decay;
  logic [4:0] env_load_val, env;

  sound_envelope #(
    .ENV_DECAY(ENV_DECAY)
  ) u_envelope (
    .clk     (clk),
    .rst     (rst),
    .clear   (env_clear),
    .load    (env_load),
    .load_val(env_load_val),
    .decay   (env_decay),
    .env     (env)
  );

  // Next-state: stop > start > frame_tick; a step load replaces that tick's decay.
  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    step_d       = step_q;
    note_d       = note_q;
    valid_d      = 1'b0;
    done_d       = 1'b0;
    go_idle      = 1'b0;
    do_load      = 1'b0;
    load_idx     = 4'd0;
    env_clear    = 1'b0;
    env_load     = 1'b0;
    env_load_val = 5'd0;
    env_decay    = 1'b0;

    if (stop) begin
      if (state_q != StIdle) go_idle = 1'b1;
    end else if (start) begin
      state_d = StPlay;
      do_load = 1'b1;
    end else begin
      unique case (state_q)
        StPlay: begin
          if (frame_tick) begin
            if (frame_cnt_q == 4'd1) begin
              if (step_q < LastStep) begin
                do_load  = 1'b1;
                load_idx = step_q + 4'd1;
              end else if (loop_en) begin
                do_load = 1'b1;
              end else begin
                // Last note keeps ringing; envelope decays out in TAIL.
                state_d = StTail;
              end
            end else begin
              frame_cnt_d = frame_cnt_q - 4'd1;
              env_decay   = 1'b1;
            end
          end
        end
        StTail: begin
          if (env == 5'd0) begin
            go_idle = 1'b1;
            done_d  = 1'b1;
          end else if (frame_tick) begin
            env_decay = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (go_idle) begin
      state_d     = StIdle;
      step_d      = 4'd0;
      note_d      = NOTE_REST;
      frame_cnt_d = 4'd0;
      env_clear   = 1'b1;
    end

    if (do_load) begin
      step_d       = load_idx;
      note_d       = song_freq(load_idx);
      env_load     = 1'b1;
      env_load_val = note_env(song_freq(load_idx));
      valid_d      = 1'b1;
      frame_cnt_d  = StepTicks;
    end

    playing_d = (state_d != StIdle);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      frame_cnt_q <= 4'd0;
      step_q      <= 4'd0;
      note_q      <= 5'd0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      playing_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      step_q      <= step_d;
      note_q      <= note_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      playing_q   <= playing_d;
    end
  end

  assign note_freq  = note_q;
  assign envelope   = env;
  assign note_valid = valid_q;
  assign step_idx   = step_q;
  assign playing    = playing_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Scoreboard bench: two sequencers (decay 8 and decay 31) driven by shared stimulus.
module tb_sound_sequencer;

  localparam int FPS = 4;

  typedef struct packed {
    logic [3:0] step;
    logic [4:0] note;
    logic [4:0] env;
    logic       valid;
    logic       done;
    logic       playing;
  } obs_t;

  typedef struct {
    int   inst;
    obs_t o;
  } ev_t;

  logic clk, rst, frame_tick, start, stop, loop_en;
  logic [4:0] nf [2];
  logic [4:0] en [2];
  logic [3:0] si [2];
  logic       nv [2];
  logic       pl [2];
  logic       dn [2];

  sound_sequencer #(.FRAMES_PER_STEP(4), .ENV_DECAY(8), .NUM_STEPS(16)) u_dut0 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .stop(stop),
    .loop_en(loop_en), .note_freq(nf[0]), .envelope(en[0]), .note_valid(nv[0]),
    .step_idx(si[0]), .playing(pl[0]), .done(dn[0])
  );

  sound_sequencer #(.FRAMES_PER_STEP(4), .ENV_DECAY(31), .NUM_STEPS(16)) u_dut1 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .stop(stop),
    .loop_en(loop_en), .note_freq(nf[1]), .envelope(en[1]), .note_valid(nv[1]),
    .step_idx(si[1]), .playing(pl[1]), .done(dn[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: song position, envelope level and mode per instance.
  int song_tbl [16] = '{25, 24, 28, 0, 25, 24, 28, 28, 25, 24, 0, 28, 25, 25, 24, 0};
  int decay_amt [2] = '{8, 31};
  int m_mode [2];   // 0 idle, 1 play, 2 tail
  int m_step [2];
  int m_ticks [2];  // ticks elapsed inside the current step
  int m_env [2];
  int m_note [2];

  obs_t lvl_q [$];
  ev_t  ev_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic m_zero(input int i);
    m_mode[i] = 0; m_step[i] = 0; m_ticks[i] = 0; m_env[i] = 0; m_note[i] = 0;
  endtask

  task automatic m_load(input int i, input int s);
    m_step[i]  = s;
    m_note[i]  = song_tbl[s];
    m_env[i]   = (song_tbl[s] == 0) ? 0 : 31;
    m_ticks[i] = 0;
    m_mode[i]  = 1;
  endtask

  task automatic model_step(input int i, input bit r, input bit st, input bit sp,
                            input bit tk, input bit lp, output obs_t o);
    bit v = 1'b0;
    bit d = 1'b0;
    if (r) begin
      m_zero(i);
    end else if (sp) begin
      if (m_mode[i] != 0) m_zero(i);
    end else if (st) begin
      m_load(i, 0);
      v = 1'b1;
    end else if (m_mode[i] == 1 && tk) begin
      m_ticks[i]++;
      if (m_ticks[i] == FPS) begin
        if (m_step[i] < 15) begin
          m_load(i, m_step[i] + 1); v = 1'b1;
        end else if (lp) begin
          m_load(i, 0); v = 1'b1;
        end else begin
          m_mode[i] = 2;
        end
      end else begin
        m_env[i] = (m_env[i] > decay_amt[i]) ? m_env[i] - decay_amt[i] : 0;
      end
    end else if (m_mode[i] == 2) begin
      if (m_env[i] == 0) begin
        m_zero(i);
        d = 1'b1;
      end else if (tk) begin
        m_env[i] = (m_env[i] > decay_amt[i]) ? m_env[i] - decay_amt[i] : 0;
      end
    end
    o.step    = 4'(m_step[i]);
    o.note    = 5'(m_note[i]);
    o.env     = 5'(m_env[i]);
    o.valid   = v;
    o.done    = d;
    o.playing = (m_mode[i] != 0);
  endtask

  function automatic obs_t get_obs(input int i);
    obs_t o;
    o.step = si[i]; o.note = nf[i]; o.env = en[i];
    o.valid = nv[i]; o.done = dn[i]; o.playing = pl[i];
    return o;
  endfunction

  // One clock of stimulus; expectations for both instances go to the scoreboard.
  task automatic drive(input bit r, input bit st, input bit sp, input bit tk, input bit lp);
    obs_t o;
    ev_t  e;
    @(negedge clk);
    rst = r; start = st; stop = sp; frame_tick = tk; loop_en = lp;
    for (int i = 0; i < 2; i++) begin
      model_step(i, r, st, sp, tk, lp, o);
      lvl_q.push_back(o);
      if (o.valid || o.done) begin
        e.inst = i;
        e.o    = o;
        ev_q.push_back(e);
      end
    end
  endtask

  task automatic run(input int n, input int per, input bit lp);
    for (int c = 0; c < n; c++) drive(1'b0, 1'b0, 1'b0, (c % per) == per - 1, lp);
  endtask

  // Monitor: level check every cycle, event check whenever a DUT pulses.
  initial begin
    obs_t got, exp_o;
    ev_t  e;
    forever begin
      @(posedge clk);
      #1;
      if (lvl_q.size() >= 2) begin
        for (int i = 0; i < 2; i++) begin
          exp_o = lvl_q.pop_front();
          got   = get_obs(i);
          n_tests++;
          if (got !== exp_o) begin
            n_fail++;
            $display("FAIL level inst%0d t=%0t got step=%0d note=%0d env=%0d v=%b d=%b p=%b exp step=%0d note=%0d env=%0d v=%b d=%b p=%b",
                     i, $time, got.step, got.note, got.env, got.valid, got.done, got.playing,
                     exp_o.step, exp_o.note, exp_o.env, exp_o.valid, exp_o.done, exp_o.playing);
          end
          if (got.valid || got.done) begin
            n_tests++;
            if (ev_q.size() == 0 || ev_q[0].inst != i) begin
              n_fail++;
              $display("FAIL event inst%0d t=%0t got unexpected v=%b d=%b step=%0d exp no event",
                       i, $time, got.valid, got.done, got.step);
            end else begin
              e = ev_q.pop_front();
              if (e.o !== got) begin
                n_fail++;
                $display("FAIL event inst%0d t=%0t got step=%0d note=%0d env=%0d v=%b d=%b exp step=%0d note=%0d env=%0d v=%b d=%b",
                         i, $time, got.step, got.note, got.env, got.valid, got.done,
                         e.o.step, e.o.note, e.o.env, e.o.valid, e.o.done);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; frame_tick = 1'b0; loop_en = 1'b0;
    for (int i = 0; i < 2; i++) m_zero(i);

    // Reset, then idle with frame ticks and no start.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run(40, 4, 1'b0);

    // Full song without looping: tail, done pulse, back to idle.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(64 * 3 + 20, 3, 1'b0);

    // Looping song wraps to step 0.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    run(64 * 2 + 10, 2, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Stop mid-step 6.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(26 * 2, 2, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run(10, 2, 1'b0);

    // Restart at step 9, then start+stop together.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(37 * 2, 2, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(10, 2, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run(6, 2, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Start coinciding with a frame tick.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    run(20, 2, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic.
    begin
      bit lp = 1'b0;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 399) == 0) lp = ~lp;
        drive($urandom_range(0, 1999) == 0, $urandom_range(0, 299) == 0,
              $urandom_range(0, 499) == 0, $urandom_range(0, 3) == 0, lp);
      end
    end
    run(4, 2, 1'b0);

    @(posedge clk);
    #2;
    n_tests++;
    if (ev_q.size() != 0 || lvl_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got events_left=%0d levels_left=%0d exp 0 and 0",
               ev_q.size(), lvl_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
- Frame-rate sequencer that drives the square-wave lead voice.
- Steps through a fixed 16-step song table, one step per FRAMES_PER_STEP video frames.
- Emits the note period code and a decaying 5-bit envelope for the tone/gate datapath.
- Sits between the VGA timing generator (frame_tick) and the sound output stage; handles start/stop, looping and end-of-song tail.

Parameters:
FRAMES_PER_STEP, 4, frame_ticks per song step (1..15)
ENV_DECAY, 8, amount subtracted from envelope per frame_tick (1..31)
NUM_STEPS, 16, song length in steps (power of two, max 16)

Ports:
clk  in  1  system/pixel clock
rst  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
start  in  1  one-cycle request: (re)start song at step 0
stop  in  1  one-cycle request: abort playback
loop_en  in  1  level; sampled at end of last step
note_freq  out  5  lead period code to tone generator; 0 = rest
envelope  out  5  gate-width envelope, 31 = full
note_valid  out  1  one-cycle pulse when a new step's note is loaded
step_idx  out  4  current step index
playing  out  1  high in PLAY or TAIL
done  out  1  one-cycle pulse on natural song end

Behaviour:
- Clocking/reset: single clock clk; rst is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE; note_freq=0, envelope=0, step_idx=0; note_valid=0, playing=0, done=0; frame_cnt=0.
- FSM states: IDLE, PLAY, TAIL.
- IDLE:
  - Outputs are held at reset values.
  - start -> PLAY. On the next cycle: step_idx=0, note_freq=SONG_FREQ[0], envelope=ENV_MAX (31), or 0 if the freq is a rest; note_valid=1 for that cycle; frame_cnt=FRAMES_PER_STEP.
- PLAY, on each frame_tick:
  - Envelope update: envelope <= (envelope > ENV_DECAY) ? envelope-ENV_DECAY : 0 (saturating, never wraps).
  - frame_cnt decrements.
  - On the tick where frame_cnt==1, the step ends. Each step therefore spans exactly FRAMES_PER_STEP ticks.
  - Step end, step_idx<NUM_STEPS-1: load step_idx+1 and its freq, reload the envelope (31, or 0 for a rest), pulse note_valid, reload frame_cnt. This replaces the decay for that tick.
  - Step end, last step with loop_en=1: wrap step_idx to 0 and load as above.
  - Step end, last step with loop_en=0: go to TAIL. note_freq and envelope hold at this transition.
- TAIL:
  - Each frame_tick decays the envelope as above.
  - When envelope==0 (checked every cycle), the next cycle goes to IDLE with done=1 for one cycle and all other outputs at reset values.
- Priorities:
  - rst > stop > start > frame_tick.
  - stop in PLAY/TAIL: IDLE on the next cycle, outputs zeroed, no done pulse.
  - stop in IDLE: no effect.
  - start in PLAY/TAIL: restart at step 0 exactly as from IDLE, including the note_valid pulse.
  - start and frame_tick in the same cycle: the tick is ignored.
  - stop and start in the same cycle: stop wins.
- Between frame_ticks, note_freq, envelope and step_idx are stable.
- Widths:
  - frame_cnt is 4 bits.
  - Envelope arithmetic is done at 6 bits with saturation, then truncated to 5.
  - step_idx wrap uses NUM_STEPS-1 compare, not natural overflow.

Decomposition:
- Shared package sound_pkg:
  - state enum seq_state_t {IDLE, PLAY, TAIL};
  - ENV_MAX=5'd31;
  - note codes NOTE_REST=0, NOTE_A=28, NOTE_B=25, NOTE_C=24;
  - SONG_FREQ[0:15] = 25,24,28,0, 25,24,28,28, 25,24,0,28, 25,25,24,0.
- One sub-module, sound_envelope: saturating decay register with load/decay/clear inputs.

Test Plan:
- Reset then idle: rst high 2 cycles, 10 frame_ticks, no start -> all outputs 0, playing 0.
- Basic play: start, loop_en=0, FRAMES_PER_STEP=4.
  - Next cycle: step_idx=0, note_freq=25, envelope=31, note_valid=1.
  - Ticks 1..3: envelope 23, 15, 7.
  - Tick 4: step_idx=1, note_freq=24, envelope=31.
- Rest step and song end: with loop_en=0, step 3 gives note_freq=0, envelope=0. After 64 ticks the FSM enters TAIL; step 15 is a rest, so envelope=0 and there is a done pulse 1 cycle later, then playing=0.
- Loop: loop_en=1 -> after 64 ticks, step_idx wraps to 0, note_freq=25, note_valid=1, no done pulse.
- Abort and restart:
  - stop mid-step 6 -> next cycle all outputs 0, no done pulse.
  - start at step 9 -> step_idx=0 reload.
  - start+stop in the same cycle -> IDLE.
- Saturation: ENV_DECAY=31 -> envelope 31 then 0 on the first tick, never wrapping. start and frame_tick in the same cycle -> envelope stays 31 and frame_cnt=4.
